// File: rtl/remote_req_credit_arbiter.sv
// Arbitrates the single remote-request path between icache fetch and the LSU.
// Also owns the outstanding-request credit counter and the fence-completion indication.
module remote_req_credit_arbiter #(
  parameter int max_out_credits_p = 16,
  parameter int req_width_p = 128,
  parameter int starve_limit_p = 4,
  localparam int credit_counter_width_lp = $clog2(max_out_credits_p + 1)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               ifetch_v_i,
  input  logic [req_width_p-1:0]             ifetch_req_i,
  output logic                               ifetch_yumi_o,
  input  logic                               lsu_v_i,
  input  logic [req_width_p-1:0]             lsu_req_i,
  output logic                               lsu_yumi_o,
  input  logic                               fence_i,
  output logic                               fence_done_o,
  output logic [req_width_p-1:0]             remote_req_o,
  output logic                               remote_req_v_o,
  input  logic                               remote_req_credit_i,
  output logic [credit_counter_width_lp-1:0] out_credits_o
);

  localparam int starve_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [credit_counter_width_lp-1:0] max_credits_lp =
    credit_counter_width_lp'(max_out_credits_p);
  localparam logic [starve_width_lp-1:0] starve_max_lp = starve_width_lp'(starve_limit_p);

  // Handshake: a requester holds v_i and its request stable until it sees its yumi;
  // yumi is combinational from v_i and means the request is consumed at this clock edge.
  logic [credit_counter_width_lp-1:0] credits_r;
  logic [starve_width_lp-1:0]         starve_r;
  logic                               have_credit;
  logic                               fetch_force;
  logic                               ifetch_grant;
  logic                               lsu_grant;
  logic                               grant;

  always_comb begin
    have_credit  = (credits_r != '0);
    fetch_force  = ifetch_v_i && (starve_r == starve_max_lp);
    ifetch_grant = 1'b0;
    lsu_grant    = 1'b0;
    if (have_credit) begin
      if (fetch_force) ifetch_grant = 1'b1;
      else if (lsu_v_i && !fence_i) lsu_grant = 1'b1;
      else if (ifetch_v_i) ifetch_grant = 1'b1;
    end
    grant = ifetch_grant || lsu_grant;
  end

  assign ifetch_yumi_o = ifetch_grant;
  assign lsu_yumi_o    = lsu_grant;
  assign out_credits_o = credits_r;
  assign fence_done_o  = (credits_r == max_credits_lp) && !remote_req_v_o && !ifetch_v_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits_r      <= max_credits_lp;
      starve_r       <= '0;
      remote_req_v_o <= 1'b0;
      remote_req_o   <= '0;
    end else begin
      remote_req_v_o <= grant;
      if (grant) remote_req_o <= ifetch_grant ? ifetch_req_i : lsu_req_i;

      // Starvation only counts LSU wins that fetch actually waited through.
      if (!ifetch_v_i || ifetch_grant) starve_r <= '0;
      else if (lsu_grant && (starve_r != starve_max_lp))
        starve_r <= starve_r + starve_width_lp'(1);

      case ({grant, remote_req_credit_i})
        2'b10:   credits_r <= credits_r - credit_counter_width_lp'(1);
        2'b01:   if (credits_r != max_credits_lp)
                   credits_r <= credits_r + credit_counter_width_lp'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(ifetch_yumi_o && lsu_yumi_o)) else $error("both yumis asserted");
      assert (!(remote_req_credit_i && credits_r == max_credits_lp))
        else $error("credit returned with counter at max");
      assert (!(grant && credits_r == '0)) else $error("grant with zero credits");
    end
  end
`endif

endmodule

// File: tb/tb_remote_req_credit_arbiter.sv
// Directed bench for remote_req_credit_arbiter: arbitration order, credit accounting,
// fence completion and asynchronous reset, with hand-computed expected values.
module tb_remote_req_credit_arbiter;

  localparam int req_w = 128;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic             ifetch_v_i;
  logic [req_w-1:0] ifetch_req_i;
  logic             ifetch_yumi_o;
  logic             lsu_v_i;
  logic [req_w-1:0] lsu_req_i;
  logic             lsu_yumi_o;
  logic             fence_i;
  logic             fence_done_o;
  logic [req_w-1:0] remote_req_o;
  logic             remote_req_v_o;
  logic             remote_req_credit_i;
  logic [4:0]       out_credits_o;

  int checks = 0;
  int errors = 0;

  remote_req_credit_arbiter dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .ifetch_v_i(ifetch_v_i), .ifetch_req_i(ifetch_req_i), .ifetch_yumi_o(ifetch_yumi_o),
    .lsu_v_i(lsu_v_i), .lsu_req_i(lsu_req_i), .lsu_yumi_o(lsu_yumi_o),
    .fence_i(fence_i), .fence_done_o(fence_done_o),
    .remote_req_o(remote_req_o), .remote_req_v_o(remote_req_v_o),
    .remote_req_credit_i(remote_req_credit_i), .out_credits_o(out_credits_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [req_w-1:0] obs, input logic [req_w-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs change and outputs are read there.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic return_credits(input int n);
    remote_req_credit_i = 1'b1;
    repeat (n) tick();
    remote_req_credit_i = 1'b0;
  endtask

  initial begin
    logic [req_w-1:0] f_req;
    logic [req_w-1:0] l_req;
    f_req = {32'hF0F0_0001, 96'h1};
    l_req = {32'hA5A5_0002, 96'h2};

    reset_n_i = 1'b0; ifetch_v_i = 1'b0; lsu_v_i = 1'b0; fence_i = 1'b0;
    remote_req_credit_i = 1'b0; ifetch_req_i = f_req; lsu_req_i = l_req;
    #23;
    check("rst_credits", 128'(out_credits_o), 128'd16);
    check("rst_valid", 128'(remote_req_v_o), 128'd0);
    check("rst_req", remote_req_o, 128'd0);
    check("rst_fence_done", 128'(fence_done_o), 128'd1);
    reset_n_i = 1'b1;
    tick();

    // single LSU request
    lsu_v_i = 1'b1;
    #1;
    check("t1_lsu_yumi", 128'(lsu_yumi_o), 128'd1);
    check("t1_if_yumi", 128'(ifetch_yumi_o), 128'd0);
    tick();
    lsu_v_i = 1'b0;
    check("t1_valid", 128'(remote_req_v_o), 128'd1);
    check("t1_req", remote_req_o, l_req);
    check("t1_credits", 128'(out_credits_o), 128'd15);
    tick();
    check("t1_valid_drop", 128'(remote_req_v_o), 128'd0);
    check("t1_req_hold", remote_req_o, l_req);
    return_credits(1);
    check("t1_credits_back", 128'(out_credits_o), 128'd16);

    // starvation: L,L,L,L,F,L
    ifetch_v_i = 1'b1; lsu_v_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t2_if_yumi%0d", i), 128'(ifetch_yumi_o), 128'(i == 4));
      check($sformatf("t2_lsu_yumi%0d", i), 128'(lsu_yumi_o), 128'(i != 4));
      tick();
      check($sformatf("t2_req%0d", i), remote_req_o, (i == 4) ? f_req : l_req);
      check($sformatf("t2_valid%0d", i), 128'(remote_req_v_o), 128'd1);
    end
    check("t2_credits", 128'(out_credits_o), 128'd10);
    check("t2_fence_done_ifv", 128'(fence_done_o), 128'd0);
    ifetch_v_i = 1'b0; lsu_v_i = 1'b0;
    return_credits(6);
    check("t2_credits_back", 128'(out_credits_o), 128'd16);

    // exhaust credits
    lsu_v_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("t3_yumi%0d", i), 128'(lsu_yumi_o), 128'd1);
      tick();
    end
    check("t3_credits0", 128'(out_credits_o), 128'd0);
    check("t3_no_yumi", 128'(lsu_yumi_o), 128'd0);
    remote_req_credit_i = 1'b1;
    #1;
    check("t3_no_yumi_same_cycle", 128'(lsu_yumi_o), 128'd0);
    tick();
    remote_req_credit_i = 1'b0;
    check("t3_credits1", 128'(out_credits_o), 128'd1);
    check("t3_yumi_after_credit", 128'(lsu_yumi_o), 128'd1);
    tick();
    check("t3_credits0_again", 128'(out_credits_o), 128'd0);
    check("t3_no_yumi_again", 128'(lsu_yumi_o), 128'd0);
    lsu_v_i = 1'b0;
    return_credits(16);
    check("t3_credits_back", 128'(out_credits_o), 128'd16);

    // grant and credit in the same cycle at 8
    lsu_v_i = 1'b1;
    repeat (8) tick();
    check("t4_credits8", 128'(out_credits_o), 128'd8);
    remote_req_credit_i = 1'b1;
    tick();
    remote_req_credit_i = 1'b0; lsu_v_i = 1'b0;
    check("t4_credits_hold", 128'(out_credits_o), 128'd8);
    return_credits(5);
    check("t4_credits13", 128'(out_credits_o), 128'd13);

    // fence with 3 outstanding
    fence_i = 1'b1; lsu_v_i = 1'b1;
    #1;
    check("t5_no_lsu_yumi", 128'(lsu_yumi_o), 128'd0);
    check("t5_fence_done0", 128'(fence_done_o), 128'd0);
    for (int i = 0; i < 3; i++) begin
      return_credits(1);
      check($sformatf("t5_fence_done_%0d", i), 128'(fence_done_o), 128'(i == 2));
      check($sformatf("t5_lsu_blocked_%0d", i), 128'(lsu_yumi_o), 128'd0);
    end
    check("t5_credits16", 128'(out_credits_o), 128'd16);
    lsu_v_i = 1'b0; fence_i = 1'b0;
    tick();

    // async reset mid-burst
    lsu_v_i = 1'b1;
    repeat (3) tick();
    check("t6_valid_before", 128'(remote_req_v_o), 128'd1);
    check("t6_credits_before", 128'(out_credits_o), 128'd13);
    #2;
    reset_n_i = 1'b0;
    lsu_v_i = 1'b0;
    #1;
    check("t6_valid_reset", 128'(remote_req_v_o), 128'd0);
    check("t6_credits_reset", 128'(out_credits_o), 128'd16);
    check("t6_req_reset", remote_req_o, 128'd0);
    #3;
    reset_n_i = 1'b1;
    tick();
    check("t6_credits_after", 128'(out_credits_o), 128'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
